// File: rtl/neopix_strip_scheduler_if.sv
// Control/status bundle between the frame scheduler, the board top level,
// the strip controllers' start/busy pins and the status LEDs.
interface neopix_strip_scheduler_if #(
    parameter int NUM_STRIPS = 4
);
    localparam int IDX_W = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;

    logic                  enable_i;
    logic                  clr_i;
    logic [NUM_STRIPS-1:0] strip_mask_i;
    logic [NUM_STRIPS-1:0] ws_bsy_i;
    logic [NUM_STRIPS-1:0] start_o;
    logic                  frame_tick_o;
    logic                  sched_bsy_o;
    logic [IDX_W-1:0]      cur_strip_o;
    logic [NUM_STRIPS-1:0] err_o;
    logic                  overrun_o;
    logic [15:0]           frame_cnt_o;

    modport master (
        input  enable_i, clr_i, strip_mask_i, ws_bsy_i,
        output start_o, frame_tick_o, sched_bsy_o, cur_strip_o, err_o, overrun_o, frame_cnt_o
    );

    modport slave (
        output enable_i, clr_i, strip_mask_i, ws_bsy_i,
        input  start_o, frame_tick_o, sched_bsy_o, cur_strip_o, err_o, overrun_o, frame_cnt_o
    );
endinterface

// File: rtl/neopix_strip_scheduler.sv
// Frame-rate sequencer: on every frame tick, starts each masked strip controller
// in turn and waits for its busy pulse, flagging start-ack and busy timeouts.
module neopix_strip_err_cell (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic set_i,
    output logic flag_o
);
    // Set has priority so a timeout coinciding with a clear is not lost.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)   flag_o <= 1'b0;
        else if (set_i) flag_o <= 1'b1;
        else if (clr_i) flag_o <= 1'b0;
    end
endmodule

module neopix_strip_scheduler #(
    parameter int NUM_STRIPS          = 4,
    parameter int SYSTEM_CLOCK        = 50000000,
    parameter int FRAME_HZ            = 60,
    parameter int START_ACK_CYCLES    = 64,
    parameter int BUSY_TIMEOUT_CYCLES = 1000000
) (
    input logic                      clk_i,
    input logic                      rst_n_i,
    neopix_strip_scheduler_if.master bus
);
    localparam int               IDX_W    = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;
    localparam logic [31:0]      PERIOD   = 32'(SYSTEM_CLOCK / FRAME_HZ);
    localparam logic [31:0]      ACK_LAST = 32'(START_ACK_CYCLES - 1);
    localparam logic [31:0]      BSY_LAST = 32'(BUSY_TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STRIPS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SCAN      = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_WAIT_ACK  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_NEXT      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]            state;
    logic [31:0]           tmr, tmr_nxt;
    logic                  tick_r;
    logic [31:0]           wcnt;
    logic [IDX_W-1:0]      idx;
    logic [NUM_STRIPS-1:0] mask_r, start_r, err_set, err_r;
    logic                  overrun_r;
    logic [15:0]           fcnt;
    logic                  en;

    assign en      = bus.enable_i;
    assign tmr_nxt = (tmr == PERIOD - 32'd1) ? 32'd0 : tmr + 32'd1;

    // The tick register is loaded from the next count so it is high exactly
    // while the counter sits at PERIOD-1.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmr    <= '0;
            tick_r <= 1'b0;
        end else if (!en) begin
            tmr    <= '0;
            tick_r <= 1'b0;
        end else begin
            tmr    <= tmr_nxt;
            tick_r <= (tmr_nxt == PERIOD - 32'd1);
        end
    end

    always_comb begin
        err_set = '0;
        if (en && state == S_WAIT_ACK && !bus.ws_bsy_i[idx] && wcnt == ACK_LAST)
            err_set[idx] = 1'b1;
        if (en && state == S_WAIT_DONE && bus.ws_bsy_i[idx] && wcnt == BSY_LAST)
            err_set[idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            idx     <= '0;
            mask_r  <= '0;
            wcnt    <= '0;
            start_r <= '0;
            fcnt    <= '0;
        end else begin
            start_r <= '0;
            if (!en) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (tick_r) begin
                        mask_r <= bus.strip_mask_i;
                        idx    <= '0;
                        state  <= S_SCAN;
                    end
                    S_SCAN: if (mask_r[idx]) begin
                        start_r <= NUM_STRIPS'(1) << idx;
                        state   <= S_START;
                    end else begin
                        state <= S_NEXT;
                    end
                    S_START: begin
                        wcnt  <= '0;
                        state <= S_WAIT_ACK;
                    end
                    // Busy is tested before expiry so a late ack still counts.
                    S_WAIT_ACK: if (bus.ws_bsy_i[idx]) begin
                        wcnt  <= '0;
                        state <= S_WAIT_DONE;
                    end else if (wcnt == ACK_LAST) begin
                        state <= S_NEXT;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
                    S_WAIT_DONE: if (!bus.ws_bsy_i[idx]) begin
                        state <= S_NEXT;
                    end else if (wcnt == BSY_LAST) begin
                        state <= S_NEXT;
                    end else begin
                        wcnt <= wcnt + 32'd1;
                    end
                    S_NEXT: if (idx == IDX_LAST) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + IDX_W'(1);
                        state <= S_SCAN;
                    end
                    S_DONE: begin
                        fcnt  <= fcnt + 16'd1;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // A tick outside IDLE is dropped; only the sticky flag records it.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                        overrun_r <= 1'b0;
        else if (tick_r && state != S_IDLE) overrun_r <= 1'b1;
        else if (bus.clr_i)                  overrun_r <= 1'b0;
    end

    for (genvar g = 0; g < NUM_STRIPS; g++) begin : g_err
        neopix_strip_err_cell u_err (
            .clk_i  (clk_i),
            .rst_n_i(rst_n_i),
            .clr_i  (bus.clr_i),
            .set_i  (err_set[g]),
            .flag_o (err_r[g])
        );
    end

    assign bus.start_o      = start_r;
    assign bus.frame_tick_o = tick_r;
    assign bus.sched_bsy_o  = (state != S_IDLE);
    assign bus.cur_strip_o  = idx;
    assign bus.err_o        = err_r;
    assign bus.overrun_o    = overrun_r;
    assign bus.frame_cnt_o  = fcnt;
endmodule

// File: tb/tb_neopix_strip_scheduler.sv
// Bench for neopix_strip_scheduler: behavioural strip models, a start-order
// scoreboard, a per-frame vector table and hand sequences for enable/reset/overrun.
module tb_neopix_strip_scheduler;
  localparam int NS = 4;
  localparam int NV = 10;

  typedef struct packed {
    logic [NS-1:0]      mask;
    logic [NS-1:0][7:0] ack;   // cycles from start to busy; 0 = never acks
    logic [NS-1:0][7:0] hold;  // cycles busy stays high
    logic [NS-1:0]      err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  neopix_strip_scheduler_if #(.NUM_STRIPS(NS)) bus ();

  neopix_strip_scheduler #(
    .NUM_STRIPS(NS), .SYSTEM_CLOCK(1000), .FRAME_HZ(10),
    .START_ACK_CYCLES(8), .BUSY_TIMEOUT_CYCLES(50)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  logic [NS-1:0] started_acc = '0;
  logic [NS-1:0] prev_start = '0;
  logic prev_tick = 1'b0;
  int ack_dly[NS];
  int hold[NS];
  int dly_cnt[NS];
  int hold_cnt[NS];
  logic [NS-1:0] bsy_m;
  vec_t tbl[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Strip models and start-order monitor, both on the falling edge.
  initial begin
    bsy_m = '0;
    for (int i = 0; i < NS; i++) begin dly_cnt[i] = 0; hold_cnt[i] = 0; end
    bus.ws_bsy_i = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (bsy_m[i]) begin
          if (hold_cnt[i] <= 1) bsy_m[i] = 1'b0;
          else hold_cnt[i]--;
        end else if (dly_cnt[i] > 0) begin
          dly_cnt[i]--;
          if (dly_cnt[i] == 0) begin bsy_m[i] = 1'b1; hold_cnt[i] = hold[i]; end
        end
        if (bus.start_o[i] && ack_dly[i] > 0) dly_cnt[i] = ack_dly[i];
      end
      bus.ws_bsy_i = bsy_m;
      if (bus.start_o != '0) begin
        chk("start_one_hot", $countones(bus.start_o), 1);
        chk("start_single_cycle", prev_start & bus.start_o, 0);
        if (exp_q.size() == 0) chk("start_unexpected", bus.start_o, 0);
        else chk("start_order", bus.start_o, 32'(1) << exp_q.pop_front());
        started_acc = started_acc | bus.start_o;
      end
      if (bus.frame_tick_o) chk("tick_single_cycle", prev_tick, 0);
      prev_start = bus.start_o;
      prev_tick  = bus.frame_tick_o;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic load_vec(input vec_t v);
    for (int j = 0; j < NS; j++) begin
      ack_dly[j] = int'(v.ack[j]);
      hold[j]    = int'(v.hold[j]);
      if (v.mask[j]) exp_q.push_back(j);
    end
    bus.strip_mask_i = v.mask;
    started_acc = '0;
  endtask

  task automatic wait_tick(input string name);
    int k = 0;
    while (bus.frame_tick_o !== 1'b1 && k < 300) begin step(1); k++; end
    chk(name, bus.frame_tick_o, 1);
  endtask

  // Count rising edges from the current point until frame_tick_o is seen.
  task automatic tick_latency(input string name);
    int k = 0;
    do begin step(1); k++; end while (bus.frame_tick_o !== 1'b1 && k < 300);
    chk(name, k, 99);
  endtask

  task automatic wait_seq(input string name);
    int k = 0;
    step(1);
    while (bus.sched_bsy_o === 1'b1 && k < 600) begin step(1); k++; end
    chk(name, bus.sched_bsy_o, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, bus.start_o, 0);
    chk({tag, "_tick"}, bus.frame_tick_o, 0);
    chk({tag, "_bsy"}, bus.sched_bsy_o, 0);
    chk({tag, "_cur"}, bus.cur_strip_o, 0);
    chk({tag, "_err"}, bus.err_o, 0);
    chk({tag, "_ovr"}, bus.overrun_o, 0);
    chk({tag, "_fcnt"}, bus.frame_cnt_o, 0);
  endtask

  initial begin
    int   k;
    int   exp_fc;
    logic seen;
    vec_t v;

    for (int i = 0; i < NV; i++) begin
      tbl[i].mask = '1;
      tbl[i].err  = '0;
      for (int j = 0; j < NS; j++) begin tbl[i].ack[j] = 8'd2; tbl[i].hold[j] = 8'd10; end
    end
    tbl[1].mask = 4'b0101;
    tbl[2].ack[1] = 8'd0;  tbl[2].err = 4'b0010;
    tbl[3].mask = 4'b0000;
    tbl[4].mask = 4'b1010; tbl[4].ack[3] = 8'd0; tbl[4].err = 4'b1000;
    tbl[5].mask = 4'b0001; tbl[5].hold[0] = 8'd60; tbl[5].err = 4'b0001;
    tbl[6].ack[2] = 8'd8;
    tbl[7].ack[2] = 8'd9;  tbl[7].err = 4'b0100;
    tbl[8].mask = 4'b0001; tbl[8].hold[0] = 8'd50;
    tbl[9].mask = 4'b0001; tbl[9].hold[0] = 8'd51; tbl[9].err = 4'b0001;

    bus.enable_i = 1'b0;
    bus.clr_i    = 1'b0;
    bus.strip_mask_i = '0;
    load_vec(tbl[0]);
    step(3);
    chk_all_zero("reset");

    rst_n = 1'b1;
    bus.enable_i = 1'b1;
    tick_latency("first_tick_latency");

    exp_fc = 0;
    for (int i = 0; i < NV; i++) begin
      if (i > 0) begin load_vec(tbl[i]); wait_tick("vec_tick"); end
      wait_seq("vec_seq_done");
      exp_fc++;
      chk("vec_started", started_acc, tbl[i].mask);
      chk("vec_queue_empty", exp_q.size(), 0);
      chk("vec_err", bus.err_o, tbl[i].err);
      chk("vec_frame_cnt", bus.frame_cnt_o, exp_fc);
      chk("vec_overrun", bus.overrun_o, 0);
      chk("vec_cur_strip_end", bus.cur_strip_o, NS - 1);
      bus.clr_i = 1'b1;
      step(1);
      bus.clr_i = 1'b0;
      chk("vec_err_cleared", bus.err_o, 0);
    end

    // Long busy on every strip pushes the sequence past the next tick.
    v = tbl[0];
    for (int j = 0; j < NS; j++) v.hold[j] = 8'd40;
    v.hold[3] = 8'd200;
    load_vec(v);
    wait_tick("ovr_tick");
    wait_seq("ovr_seq_done");
    bus.enable_i = 1'b0;
    exp_fc++;
    chk("ovr_flag", bus.overrun_o, 1);
    chk("ovr_err3", bus.err_o, 4'b1000);
    chk("ovr_frame_cnt", bus.frame_cnt_o, exp_fc);
    chk("ovr_started", started_acc, 4'b1111);
    k = 0;
    while (bus.ws_bsy_i !== '0 && k < 400) begin step(1); k++; end
    chk("ovr_strips_idle", bus.ws_bsy_i, 0);
    bus.clr_i = 1'b1;
    step(1);
    bus.clr_i = 1'b0;
    chk("ovr_cleared", bus.overrun_o, 0);
    chk("ovr_err_cleared", bus.err_o, 0);

    // Drop enable while strip 0 is mid-busy.
    v = tbl[0];
    v.mask = 4'b0001;
    v.hold[0] = 8'd40;
    load_vec(v);
    bus.enable_i = 1'b1;
    tick_latency("reenable_tick_latency");
    k = 0;
    while (bus.ws_bsy_i[0] !== 1'b1 && k < 200) begin step(1); k++; end
    chk("dis_busy0_seen", bus.ws_bsy_i[0], 1);
    step(3);
    chk("dis_bsy_before", bus.sched_bsy_o, 1);
    bus.enable_i = 1'b0;
    step(1);
    chk("dis_bsy_after", bus.sched_bsy_o, 0);
    chk("dis_frame_cnt", bus.frame_cnt_o, exp_fc);
    seen = 1'b0;
    for (int c = 0; c < 150; c++) begin step(1); if (bus.frame_tick_o) seen = 1'b1; end
    chk("dis_no_tick", seen, 0);
    chk("dis_frame_cnt_hold", bus.frame_cnt_o, exp_fc);

    // Asynchronous reset in the middle of a sequence.
    load_vec(tbl[0]);
    bus.enable_i = 1'b1;
    tick_latency("timer_held_latency");
    k = 0;
    while (!started_acc[1] && k < 200) begin step(1); k++; end
    chk("rst_strip1_started", started_acc[1], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_q.delete();
    bus.strip_mask_i = '0;
    step(2);
    rst_n = 1'b1;
    tick_latency("post_reset_tick_latency");
    chk("post_reset_fcnt", bus.frame_cnt_o, 0);
    bus.enable_i = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
